// File: rtl/rv_rf_pkg.sv
// Shared constants and write-priority helper for the multi-port register file.
// Used by rv_regfile_mp and rv_rf_scoreboard.
package rv_rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_W0   = 2'd1,
        SEL_W1   = 2'd2
    } wsel_e;

    // W1 (load) takes priority over W0 (ALU) when both hit the same register.
    function automatic wsel_e wr_sel(input logic i_w1_hit, input logic i_w0_hit);
        if (i_w1_hit)
            return SEL_W1;
        else if (i_w0_hit)
            return SEL_W0;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/rv_rf_scoreboard.sv
// Busy scoreboard: one flop per register, set on load issue, cleared on W1 writeback.
// Register 0 is never busy.
module rv_rf_scoreboard
    import rv_rf_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            Clk,
    input  logic            rst_n,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic            w1_en,
    input  logic [AW-1:0]   w1_addr,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] r_busy;

    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy[REG_ZERO] <= 1'b0;
            // Set beats clear so back-to-back loads to the same rd stay pending.
            for (int i = 1; i < NREG; i++) begin
                if (iss_en && (iss_rd == AW'(i)))
                    r_busy[i] <= 1'b1;
                else if (w1_en && (w1_addr == AW'(i)))
                    r_busy[i] <= 1'b0;
            end
        end
    end

    assign busy_vec = r_busy;

endmodule

// File: rtl/rv_regfile_mp.sv
// Multi-port RISC-V integer register file with two write ports and a load scoreboard.
// Define REGFILE_BYPASS_EN for write-first forwarding on the read ports.
module rv_regfile_mp
    import rv_rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2
) (
    input  logic              Clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              w0_en,
    input  logic [AW-1:0]     w0_addr,
    input  logic [XLEN-1:0]   w0_data,
    input  logic              w1_en,
    input  logic [AW-1:0]     w1_addr,
    input  logic [XLEN-1:0]   w1_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    output logic [NREG-1:0]   busy_vec
);

    logic [XLEN-1:0] r_regs [NREG];

    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                unique case (wr_sel(w1_en && (w1_addr == AW'(i)),
                                    w0_en && (w0_addr == AW'(i))))
                    SEL_W1:  r_regs[i] <= w1_data;
                    SEL_W0:  r_regs[i] <= w0_data;
                    default: ;
                endcase
            end
        end
    end

    rv_rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .Clk      (Clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .w1_en    (w1_en),
        .w1_addr  (w1_addr),
        .busy_vec (busy_vec)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic            w_nz;
        logic [XLEN-1:0] w_store;
        logic [XLEN-1:0] w_data;
        logic            w_bsy;

        assign w_addr  = rd_addr[k*AW +: AW];
        assign w_nz    = (w_addr != AW'(REG_ZERO));
        assign w_store = w_nz ? r_regs[w_addr] : '0;

`ifdef REGFILE_BYPASS_EN
        logic  w_w1_hit;
        logic  w_w0_hit;
        wsel_e w_sel;

        assign w_w1_hit = w1_en && (w1_addr == w_addr) && w_nz;
        assign w_w0_hit = w0_en && (w0_addr == w_addr) && w_nz;
        assign w_sel    = wr_sel(w_w1_hit, w_w0_hit);
        assign w_data   = (w_sel == SEL_W1) ? w1_data :
                          (w_sel == SEL_W0) ? w0_data : w_store;
        // A landing load resolves the hazard in the same cycle it is forwarded.
        assign w_bsy    = busy_vec[w_addr] && w_nz && !w_w1_hit;
`else
        assign w_data   = w_store;
        assign w_bsy    = busy_vec[w_addr] && w_nz;
`endif

        assign rd_data[k*XLEN +: XLEN] = w_data;
        assign rd_busy[k]              = w_bsy;
    end

endmodule
